// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath: sequences IF/ID/EXEC/MEM/WB,
// handles a variable-latency memory handshake, traps illegal instructions and counts retirements.
module multicycle_ctrl #(
   parameter int INSTR_W       = 32,
   parameter int CNT_W         = 32,
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr,
   input  logic               alu_zero,
   input  logic               mem_ready,
   input  logic               halt,
   output logic               pc_we,
   output logic               ir_we,
   output logic               a_we,
   output logic               b_we,
   output logic               reg_we,
   output logic               mem_we,
   output logic               mem_req,
   output logic [1:0]         reg_dst,
   output logic [1:0]         wb_sel,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [2:0]         alu_op,
   output logic [1:0]         pc_src,
   output logic [2:0]         state,
   output logic               illegal,
   output logic [CNT_W-1:0]   retired
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EXEC = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_TRAP = 3'd5,
      S_HALT = 3'd6
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_XOR = 3'd2;
   localparam logic [2:0] ALU_SLT = 3'd3;

   state_t             state_q, state_d;
   logic               fetch_q, fetch_d;
   logic               illegal_q, illegal_d;
   logic [CNT_W-1:0]   retired_q, retired_d;

   logic [5:0] opcode, funct;
   logic       mem_rdy, is_rtype, legal;
   logic       pc_we_c, ir_we_c, a_we_c, b_we_c, reg_we_c, mem_we_c, mem_req_c;
   logic       unused_instr;

   assign opcode       = instr[INSTR_W-1 -: 6];
   assign funct        = instr[5:0];
   assign unused_instr = ^instr[INSTR_W-7:6];
   assign mem_rdy      = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign is_rtype     = (opcode == OP_RTYPE);

   always_comb begin
      legal = 1'b0;
      case (opcode)
         OP_RTYPE: legal = (funct == FN_ADD) || (funct == FN_SUB) ||
                           (funct == FN_SLT) || (funct == FN_JR);
         OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_XORI, OP_LW, OP_SW: legal = 1'b1;
         default:  legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      fetch_d   = 1'b0;
      pc_we_c   = 1'b0;
      ir_we_c   = 1'b0;
      a_we_c    = 1'b0;
      b_we_c    = 1'b0;
      reg_we_c  = 1'b0;
      mem_we_c  = 1'b0;
      mem_req_c = 1'b0;
      reg_dst   = 2'd0;
      wb_sel    = 2'd0;
      alu_src_a = 2'd0;
      alu_src_b = 2'd0;
      alu_op    = ALU_ADD;
      pc_src    = 2'd0;
      case (state_q)
         S_IF: begin
            // halt is honoured only before a fetch has been issued
            if (!fetch_q && halt) begin
               state_d = S_HALT;
            end else begin
               mem_req_c = 1'b1;
               alu_src_b = 2'd3;
               if (mem_rdy) begin
                  ir_we_c = 1'b1;
                  pc_we_c = 1'b1;
                  state_d = S_ID;
               end else begin
                  fetch_d = 1'b1;
               end
            end
         end
         S_ID: begin
            a_we_c    = 1'b1;
            b_we_c    = 1'b1;
            alu_src_b = 2'd2;
            if (!legal) begin
               state_d = S_TRAP;
            end else if (opcode == OP_J) begin
               pc_we_c = 1'b1;
               pc_src  = 2'd1;
               state_d = S_IF;
            end else if (opcode == OP_JAL) begin
               pc_we_c  = 1'b1;
               pc_src   = 2'd1;
               reg_we_c = 1'b1;
               reg_dst  = 2'd2;
               wb_sel   = 2'd2;
               state_d  = S_IF;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (opcode)
               OP_LW, OP_SW: begin
                  alu_src_a = 2'd1;
                  alu_src_b = 2'd1;
                  state_d   = S_MEM;
               end
               OP_ADDI, OP_XORI: begin
                  alu_src_a = 2'd1;
                  alu_src_b = 2'd1;
                  alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
                  state_d   = S_WB;
               end
               OP_BEQ, OP_BNE: begin
                  alu_op    = ALU_SUB;
                  alu_src_a = 2'd1;
                  pc_src    = 2'd3;
                  pc_we_c   = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
                  state_d   = S_IF;
               end
               OP_RTYPE: begin
                  alu_src_a = 2'd1;
                  if (funct == FN_JR) begin
                     pc_we_c = 1'b1;
                     pc_src  = 2'd2;
                     state_d = S_IF;
                  end else begin
                     alu_op  = (funct == FN_SUB) ? ALU_SUB :
                               (funct == FN_SLT) ? ALU_SLT : ALU_ADD;
                     state_d = S_WB;
                  end
               end
               default: state_d = S_TRAP;
            endcase
         end
         S_MEM: begin
            mem_req_c = 1'b1;
            mem_we_c  = (opcode == OP_SW);
            if (mem_rdy) state_d = (opcode == OP_SW) ? S_IF : S_WB;
         end
         S_WB: begin
            reg_we_c = 1'b1;
            if (opcode == OP_LW) begin
               wb_sel  = 2'd1;
               reg_dst = 2'd1;
            end else if (!is_rtype) begin
               reg_dst = 2'd1;
            end
            state_d = S_IF;
         end
         S_TRAP: state_d = S_TRAP;
         S_HALT: if (!halt) state_d = S_IF;
         default: state_d = S_IF;
      endcase
   end

   // Retirement is any return to IF from the instruction-execution states
   always_comb begin
      retired_d = retired_q;
      if (state_d == S_IF && (state_q == S_ID || state_q == S_EXEC ||
                              state_q == S_MEM || state_q == S_WB))
         retired_d = retired_q + 1'b1;
      illegal_d = illegal_q | (state_d == S_TRAP);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IF;
         fetch_q   <= 1'b0;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         fetch_q   <= fetch_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   assign pc_we   = pc_we_c   & reset;
   assign ir_we   = ir_we_c   & reset;
   assign a_we    = a_we_c    & reset;
   assign b_we    = b_we_c    & reset;
   assign reg_we  = reg_we_c  & reset;
   assign mem_we  = mem_we_c  & reset;
   assign mem_req = mem_req_c & reset;
   assign state   = state_q;
   assign illegal = illegal_q;
   assign retired = retired_q;

endmodule
